key_block_packer: RTL
=====================

Name: key_block_packer

Overview:
- Front end of the memcache key hash path. Sits directly upstream of the lookup3 hash core.
- Accepts the key as a byte stream from the memcache header/key parser.
- Packs the bytes little-endian into 12-byte blocks (k0, k1, k2) and presents one block at a time to the hash core, with end-of-key marking and the total key length.
- Zero-pads the final partial block and drops keys longer than the memcache maximum.

Parameters:
- MAX_KEY_LEN, 250: maximum accepted key length in bytes; longer keys are dropped and flagged.
- LEN_W, 16: width of the byte counter and the key_length output.

Ports:
- CLK  in  1  system clock; all logic on posedge.
- RST  in  1  synchronous active-high reset.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block accepts a byte this cycle.
- in_data  in  8  key byte.
- in_last  in  1  in_data is the final byte of the key.
- hdr_key_len  in  LEN_W  key length from the memcache header; used only when KEYPACK_LENCHK_EN is defined.
- out_valid  out  1  k0/k1/k2 block valid.
- out_ready  in  1  hash core takes the block.
- k0, k1, k2  out  32 each  packed key words.
- endofword  out  1  block is the final block of the key.
- key_length  out  LEN_W  total key bytes; meaningful when endofword=1.
- key_err  out  1  one-cycle pulse: key dropped.

Behaviour:
- Clock and reset: one clock CLK; reset RST is synchronous and active-high.
- Reset values: in_ready=1, out_valid=0, k0/k1/k2=0, endofword=0, key_length=0, key_err=0, state=FILL, byte index=0, byte count=0.
- Input handshake: a byte is consumed when in_valid && in_ready.
- States:
  - FILL: accumulates bytes; in_ready=1.
  - HOLD: a block is pending on the output; in_ready=0.
  - DROP: discards bytes until in_last; in_ready=1.
- Byte placement: byte index i (0..11) within a block goes to word i/4, bits [8*(i%4)+7 : 8*(i%4)]. k0 holds bytes 0-3, k1 bytes 4-7, k2 bytes 8-11.
  - Example: "abcd" gives k0=0x64636261.
- Block completion: a block completes when the accepted byte has i=11, or when in_last=1.
  - Next cycle: out_valid=1, k0/k1/k2 hold the packed block, and endofword=in_last of the completing byte.
  - Unfilled byte lanes of a final partial block are 0.
  - The accumulator is cleared for the next block; state goes to HOLD.
- Key length ending on a 12-byte boundary: the 12th byte carries in_last, so the block is emitted with endofword=1. No empty trailing block is emitted.
- key_length:
  - With endofword=1: total bytes of the key (byte count including the last byte).
  - Otherwise: running byte count.
  - Byte count resets to 0 after the endofword block is accepted.
- Output handshake:
  - out_valid and all output data stay stable while out_ready=0.
  - On out_valid && out_ready: out_valid→0 next cycle and state→FILL.
  - A new byte can be accepted the cycle after acceptance.
  - Throughput: 12 bytes per 13 cycles with out_ready=1.
- Key with no in_last: stays in FILL indefinitely; no timeout.
- Overflow: if an accepted byte would make byte count exceed MAX_KEY_LEN:
  - That byte and any partially filled accumulator are discarded; state→DROP.
  - Blocks already emitted (endofword=0) are not recalled.
  - In DROP, bytes are consumed and discarded. On the byte with in_last: key_err pulses for 1 cycle, byte count→0, state→FILL. No endofword block is emitted; downstream discards its partial hash on key_err.
  - If the overflowing byte itself has in_last: key_err pulses next cycle and state returns directly to FILL.
- Minimum key length is 1 byte; zero-length keys are not expressible on this interface.
- RST mid-key (any state): pending block and accumulator are discarded and all outputs return to reset values next cycle.

Optional Feature:
- Macro: KEYPACK_LENCHK_EN.
- Defined: hdr_key_len is sampled on the first byte of each key. When in_last is accepted, a count mismatch against the sampled value:
  - suppresses the endofword block;
  - pulses key_err for 1 cycle;
  - returns state to FILL.
  - A matching count behaves normally.
- Not defined: hdr_key_len is ignored and no compare logic exists.

Test Plan:
- "abcdefghijkl" (12 bytes, in_last on 'l'), out_ready=1 → one block: k0=0x64636261, k1=0x68676665, k2=0x6c6b6a69, endofword=1, key_length=12; then in_ready=1.
- "abcde" → one block: k0=0x64636261, k1=0x00000065, k2=0x00000000, endofword=1, key_length=5.
- "abcdefghijklm" (13 bytes) → block 1 as in the first test with endofword=0; block 2: k0=0x0000006d, k1=0, k2=0, endofword=1, key_length=13.
- Backpressure: hold out_ready=0 for 5 cycles after block 1 → out_valid=1 with stable k0/k1/k2, in_ready=0 throughout; out_ready=1 → out_valid=0 next cycle, input resumes.
- Overflow: 251-byte key → 20 blocks with endofword=0, no block 21, key_err pulses once on the last byte; a following "ab" key yields k0=0x00006261, key_length=2.
- RST asserted after 7 bytes of a key → out_valid=0, in_ready=1. Then "xyz" → k0=0x007a7978, key_length=3. With KEYPACK_LENCHK_EN and hdr_key_len=4 for "xyz" → no block emitted, key_err=1 for one cycle.

Source files
------------

// File: rtl/key_block_packer.sv
// key_block_packer: packs a memcache key byte stream little-endian into 12-byte
// blocks (k0, k1, k2) for the lookup3 hash core. The final partial block is zero-padded.
// Keys longer than MAX_KEY_LEN are dropped and flagged on key_err.
// Optional build macro KEYPACK_LENCHK_EN: checks the received byte count against
// hdr_key_len, which is sampled on the first byte of each key.
module key_block_packer #(
  parameter int unsigned MAX_KEY_LEN = 250,
  parameter int unsigned LEN_W       = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  input  logic [LEN_W-1:0] hdr_key_len,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      k0,
  output logic [31:0]      k1,
  output logic [31:0]      k2,
  output logic             endofword,
  output logic [LEN_W-1:0] key_length,
  output logic             key_err
);

  typedef enum logic [1:0] {StFill, StHold, StDrop} state_e;

  state_e           state_q, state_d;
  logic [95:0]      acc_q, acc_d;
  logic [3:0]       idx_q, idx_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [95:0]      blk_q, blk_d;
  logic             ov_q, ov_d;
  logic             eow_q, eow_d;
  logic [LEN_W-1:0] klen_q, klen_d;
  logic             err_q, err_d;

  logic [95:0]      blk_fill;
  logic [LEN_W-1:0] cnt_inc;
  logic             accept;
  logic             len_bad;

  assign in_ready   = (state_q != StHold);
  assign accept     = in_valid && in_ready;
  assign cnt_inc    = cnt_q + 1'b1;
  assign out_valid  = ov_q;
  assign k0         = blk_q[31:0];
  assign k1         = blk_q[63:32];
  assign k2         = blk_q[95:64];
  assign endofword  = eow_q;
  assign key_length = klen_q;
  assign key_err    = err_q;

`ifdef KEYPACK_LENCHK_EN
  logic [LEN_W-1:0] hlen_q, hlen_d;
  logic [LEN_W-1:0] exp_len;

  // The first byte of a key sees hdr_key_len directly; later bytes use the sampled copy.
  assign exp_len = (cnt_q == '0) ? hdr_key_len : hlen_q;
  assign len_bad = (cnt_inc != exp_len);

  // Capture the header length on the first accepted byte of each key.
  always_comb begin
    hlen_d = hlen_q;
    if (state_q == StFill && accept && cnt_q == '0) hlen_d = hdr_key_len;
  end

  // Header length register.
  always_ff @(posedge CLK) begin
    if (RST) hlen_q <= '0;
    else     hlen_q <= hlen_d;
  end
`else
  logic unused_hdr_key_len;
  assign unused_hdr_key_len = ^hdr_key_len;
  assign len_bad = 1'b0;
`endif

  // Accumulator with the incoming byte merged into its lane.
  always_comb begin
    blk_fill = acc_q;
    for (int i = 0; i < 12; i++) begin
      if (idx_q == 4'(i)) blk_fill[8*i +: 8] = in_data;
    end
  end

  // Next-state logic: byte accumulation, block hand-off, overflow and drop handling.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    blk_d   = blk_q;
    ov_d    = ov_q;
    eow_d   = eow_q;
    klen_d  = klen_q;
    err_d   = 1'b0;
    case (state_q)
      StFill: begin
        if (accept) begin
          if (cnt_inc > LEN_W'(MAX_KEY_LEN)) begin
            // Overflow: discard the partial block and this byte.
            acc_d = '0;
            idx_d = '0;
            if (in_last) begin
              err_d = 1'b1;
              cnt_d = '0;
            end else begin
              state_d = StDrop;
            end
          end else if (in_last && len_bad) begin
            acc_d = '0;
            idx_d = '0;
            cnt_d = '0;
            err_d = 1'b1;
          end else if (in_last || idx_q == 4'd11) begin
            blk_d   = blk_fill;
            ov_d    = 1'b1;
            eow_d   = in_last;
            klen_d  = cnt_inc;
            acc_d   = '0;
            idx_d   = '0;
            // Cleared now; no byte can be accepted before the block leaves HOLD.
            cnt_d   = in_last ? '0 : cnt_inc;
            state_d = StHold;
          end else begin
            acc_d = blk_fill;
            idx_d = idx_q + 4'd1;
            cnt_d = cnt_inc;
          end
        end
      end
      StHold: begin
        if (out_ready) begin
          ov_d    = 1'b0;
          state_d = StFill;
        end
      end
      StDrop: begin
        if (accept && in_last) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = StFill;
        end
      end
      default: state_d = StFill;
    endcase
  end

  // State and output registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StFill;
      acc_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      blk_q   <= '0;
      ov_q    <= 1'b0;
      eow_q   <= 1'b0;
      klen_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      blk_q   <= blk_d;
      ov_q    <= ov_d;
      eow_q   <= eow_d;
      klen_q  <= klen_d;
      err_q   <= err_d;
    end
  end

endmodule
